// File: rtl/diff_commit_packer.sv
// Difftest commit queue: compacts up to 2 retires + 1 exception per cycle and replays up to 4 in-order commit slots.
// Push to output in 2 cycles. in_ready needs 3 free entries. out_hold stalls the drain. Exceptions are emitted alone.
module diff_commit_packer #(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] CORE_ID = 8'd0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   in_valid,
  input  logic [127:0] in_pc,
  input  logic [63:0]  in_instr,
  input  logic [1:0]   in_skip,
  input  logic [1:0]   in_wen,
  input  logic [15:0]  in_wdest,
  input  logic [127:0] in_wdata,
  input  logic         excp_in_valid,
  input  logic         excp_in_eret,
  input  logic [10:0]  excp_in_intrNo,
  input  logic [5:0]   excp_in_cause,
  input  logic [31:0]  excp_in_pc,
  input  logic [31:0]  excp_in_inst,
  output logic         in_ready,
  input  logic         out_hold,
  output logic [7:0]   out_coreid,
  output logic [3:0]   out_valid,
  output logic [31:0]  out_index,
  output logic [255:0] out_pc,
  output logic [127:0] out_instr,
  output logic [3:0]   out_skip,
  output logic [3:0]   out_wen,
  output logic [31:0]  out_wdest,
  output logic [255:0] out_wdata,
  output logic         out_excp_valid,
  output logic         out_eret,
  output logic [10:0]  out_intrNo,
  output logic [5:0]   out_cause,
  output logic [31:0]  out_excp_pc,
  output logic [31:0]  out_excp_inst,
  output logic         overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Exception entries reuse pc[31:0] and instr for the faulting pc / instruction word.
  typedef struct packed {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        skip;
    logic        wen;
    logic [7:0]  wdest;
    logic [63:0] wdata;
    logic        eret;
    logic [10:0] intr_no;
    logic [5:0]  cause;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_in_ready, r_ovf;

  logic [3:0]   r_out_valid, r_out_skip, r_out_wen;
  logic [31:0]  r_out_index, r_out_wdest, r_out_excp_pc, r_out_excp_inst;
  logic [255:0] r_out_pc, r_out_wdata;
  logic [127:0] r_out_instr;
  logic         r_out_excp_valid, r_out_eret;
  logic [10:0]  r_out_intr_no;
  logic [5:0]   r_out_cause;

  entry_t        w_item [3];
  logic [2:0]    w_item_vld;
  logic [1:0]    w_off [3];
  logic [AW-1:0] w_waddr [3];
  logic [AW-1:0] w_raddr [4];
  logic          w_any_vld, w_acc, w_pop_excp, w_stop;
  logic [2:0]    w_pop_n;
  logic [CW-1:0] w_push_cnt, w_pop_cnt, w_next_count;

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_item[l]       = '0;
      w_item[l].pc    = in_pc[l*64 +: 64];
      w_item[l].instr = in_instr[l*32 +: 32];
      w_item[l].skip  = in_skip[l];
      w_item[l].wen   = in_wen[l];
      w_item[l].wdest = in_wdest[l*8 +: 8];
      w_item[l].wdata = in_wdata[l*64 +: 64];
    end
    w_item[2]         = '0;
    w_item[2].kind    = 1'b1;
    w_item[2].pc      = {32'd0, excp_in_pc};
    w_item[2].instr   = excp_in_inst;
    w_item[2].eret    = excp_in_eret;
    w_item[2].intr_no = excp_in_intrNo;
    w_item[2].cause   = excp_in_cause;
    w_item_vld = {excp_in_valid, in_valid};
    // Compaction: each item lands after the valid items older than it.
    w_off[0] = 2'd0;
    w_off[1] = {1'b0, in_valid[0]};
    w_off[2] = 2'(in_valid[0]) + 2'(in_valid[1]);
    for (int i = 0; i < 3; i++) w_waddr[i] = r_wptr + AW'(w_off[i]);
    w_any_vld  = |w_item_vld;
    w_acc      = w_any_vld & r_in_ready;
    w_push_cnt = w_acc ? (CW'(w_off[2]) + CW'(excp_in_valid)) : '0;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w_raddr[k] = r_rptr + AW'(k);
    w_pop_excp = !out_hold && (r_count != '0) && r_mem[r_rptr].kind;
    w_stop     = out_hold || r_mem[r_rptr].kind;
    w_pop_n    = '0;
    for (int k = 0; k < 4; k++) begin
      if (!w_stop && (CW'(k) < r_count) && !r_mem[w_raddr[k]].kind) w_pop_n = 3'(k + 1);
      else w_stop = 1'b1;
    end
    w_pop_cnt    = w_pop_excp ? CW'(1) : CW'(w_pop_n);
    w_next_count = r_count + w_push_cnt - w_pop_cnt;
  end

  always_ff @(posedge clock) begin
    if (w_acc)
      for (int i = 0; i < 3; i++)
        if (w_item_vld[i]) r_mem[w_waddr[i]] <= w_item[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;  r_rptr <= '0;  r_count <= '0;
      r_in_ready <= 1'b1;  r_ovf <= 1'b0;
      r_out_valid <= '0;  r_out_index <= '0;  r_out_pc <= '0;  r_out_instr <= '0;
      r_out_skip <= '0;  r_out_wen <= '0;  r_out_wdest <= '0;  r_out_wdata <= '0;
      r_out_excp_valid <= 1'b0;  r_out_eret <= 1'b0;  r_out_intr_no <= '0;
      r_out_cause <= '0;  r_out_excp_pc <= '0;  r_out_excp_inst <= '0;
    end else begin
      r_count    <= w_next_count;
      r_in_ready <= (CW'(DEPTH) - w_next_count) >= CW'(3);
      r_wptr     <= r_wptr + AW'(w_push_cnt);
      r_rptr     <= r_rptr + AW'(w_pop_cnt);
      if (w_any_vld && !r_in_ready) r_ovf <= 1'b1;
      r_out_valid <= '0;  r_out_index <= '0;  r_out_pc <= '0;  r_out_instr <= '0;
      r_out_skip <= '0;  r_out_wen <= '0;  r_out_wdest <= '0;  r_out_wdata <= '0;
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < w_pop_n) begin
          r_out_valid[k]          <= 1'b1;
          r_out_index[k*8 +: 8]   <= 8'(k);
          r_out_pc[k*64 +: 64]    <= r_mem[w_raddr[k]].pc;
          r_out_instr[k*32 +: 32] <= r_mem[w_raddr[k]].instr;
          r_out_skip[k]           <= r_mem[w_raddr[k]].skip;
          r_out_wen[k]            <= r_mem[w_raddr[k]].wen;
          r_out_wdest[k*8 +: 8]   <= r_mem[w_raddr[k]].wdest;
          r_out_wdata[k*64 +: 64] <= r_mem[w_raddr[k]].wdata;
        end
      end
      r_out_excp_valid <= w_pop_excp;
      r_out_eret       <= w_pop_excp & r_mem[r_rptr].eret;
      r_out_intr_no    <= w_pop_excp ? r_mem[r_rptr].intr_no : '0;
      r_out_cause      <= w_pop_excp ? r_mem[r_rptr].cause : '0;
      r_out_excp_pc    <= w_pop_excp ? r_mem[r_rptr].pc[31:0] : '0;
      r_out_excp_inst  <= w_pop_excp ? r_mem[r_rptr].instr : '0;
    end
  end

  assign in_ready       = r_in_ready;
  assign overflow_err   = r_ovf;
  assign out_coreid     = CORE_ID;
  assign out_valid      = r_out_valid;
  assign out_index      = r_out_index;
  assign out_pc         = r_out_pc;
  assign out_instr      = r_out_instr;
  assign out_skip       = r_out_skip;
  assign out_wen        = r_out_wen;
  assign out_wdest      = r_out_wdest;
  assign out_wdata      = r_out_wdata;
  assign out_excp_valid = r_out_excp_valid;
  assign out_eret       = r_out_eret;
  assign out_intrNo     = r_out_intr_no;
  assign out_cause      = r_out_cause;
  assign out_excp_pc    = r_out_excp_pc;
  assign out_excp_inst  = r_out_excp_inst;
endmodule

// File: tb/tb_diff_commit_packer.sv
// Scoreboard bench: a queue-level reference model predicts each emission; a negedge monitor pops and compares.
module tb_diff_commit_packer;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] in_valid, in_skip, in_wen;
  logic [127:0] in_pc, in_wdata;
  logic [63:0] in_instr;
  logic [15:0] in_wdest;
  logic excp_in_valid, excp_in_eret, out_hold;
  logic [10:0] excp_in_intrNo;
  logic [5:0] excp_in_cause;
  logic [31:0] excp_in_pc, excp_in_inst;
  logic in_ready, out_excp_valid, out_eret, overflow_err;
  logic [7:0] out_coreid;
  logic [3:0] out_valid, out_skip, out_wen;
  logic [31:0] out_index, out_wdest, out_excp_pc, out_excp_inst;
  logic [255:0] out_pc, out_wdata;
  logic [127:0] out_instr;
  logic [10:0] out_intrNo;
  logic [5:0] out_cause;

  always #5 clock = ~clock;

  diff_commit_packer #(.DEPTH(DEPTH), .CORE_ID(8'd0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_skip(in_skip), .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
    .excp_in_valid(excp_in_valid), .excp_in_eret(excp_in_eret), .excp_in_intrNo(excp_in_intrNo),
    .excp_in_cause(excp_in_cause), .excp_in_pc(excp_in_pc), .excp_in_inst(excp_in_inst),
    .in_ready(in_ready), .out_hold(out_hold), .out_coreid(out_coreid), .out_valid(out_valid),
    .out_index(out_index), .out_pc(out_pc), .out_instr(out_instr), .out_skip(out_skip),
    .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata), .out_excp_valid(out_excp_valid),
    .out_eret(out_eret), .out_intrNo(out_intrNo), .out_cause(out_cause), .out_excp_pc(out_excp_pc),
    .out_excp_inst(out_excp_inst), .overflow_err(overflow_err)
  );

  typedef struct {
    bit kind; logic [63:0] pc; logic [31:0] instr; logic skip, wen; logic [7:0] wdest;
    logic [63:0] wdata; logic eret; logic [10:0] intr; logic [5:0] cause; logic [31:0] epc, einst;
  } item_t;
  typedef struct {
    int due; logic [3:0] v, skip, wen; logic [31:0] idx, wdest; logic [255:0] pc, wdata;
    logic [127:0] instr; logic ev, eret; logic [10:0] intr; logic [5:0] cause; logic [31:0] epc, einst;
  } emit_t;

  item_t mq[$];
  emit_t expq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit mon_on = 0;
  bit m_ready_cur = 1, m_ready_nxt = 1, m_ovf_cur = 0, m_ovf_nxt = 0;
  logic [63:0] pc_ctr = 64'h1c00_1000;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [719:0] act, input logic [719:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: ordered list of queued items; each clock, drain from the front under the emission rules, then append accepted inputs.
  task automatic model_edge();
    emit_t e;
    item_t it;
    if (reset) begin
      mq.delete(); m_ready_nxt = 1; m_ovf_nxt = 0;
      return;
    end
    if (!out_hold && mq.size() > 0) begin
      e = '{default: 0};
      e.due = cyc + 1;
      if (mq[0].kind) begin
        it = mq.pop_front();
        e.ev = 1; e.eret = it.eret; e.intr = it.intr; e.cause = it.cause; e.epc = it.epc; e.einst = it.einst;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (mq.size() == 0 || mq[0].kind) break;
          it = mq.pop_front();
          e.v[k] = 1'b1; e.idx[k*8 +: 8] = 8'(k); e.pc[k*64 +: 64] = it.pc;
          e.instr[k*32 +: 32] = it.instr; e.skip[k] = it.skip; e.wen[k] = it.wen;
          e.wdest[k*8 +: 8] = it.wdest; e.wdata[k*64 +: 64] = it.wdata;
        end
      end
      expq.push_back(e);
    end
    if (in_valid != 2'b00 || excp_in_valid) begin
      if (m_ready_cur) begin
        for (int l = 0; l < 2; l++) begin
          if (in_valid[l]) begin
            it = '{default: 0};
            it.pc = in_pc[l*64 +: 64]; it.instr = in_instr[l*32 +: 32]; it.skip = in_skip[l];
            it.wen = in_wen[l]; it.wdest = in_wdest[l*8 +: 8]; it.wdata = in_wdata[l*64 +: 64];
            mq.push_back(it);
          end
        end
        if (excp_in_valid) begin
          it = '{default: 0};
          it.kind = 1; it.eret = excp_in_eret; it.intr = excp_in_intrNo; it.cause = excp_in_cause;
          it.epc = excp_in_pc; it.einst = excp_in_inst;
          mq.push_back(it);
        end
      end else m_ovf_nxt = 1;
    end
    m_ready_nxt = (DEPTH - mq.size()) >= 3;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    m_ready_cur = m_ready_nxt;
    m_ovf_cur = m_ovf_nxt;
  endtask

  task automatic set_in(input logic [1:0] v, input logic e, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [31:0] epc, input logic [5:0] cause);
    in_valid = v; in_pc = {pc1, pc0}; in_instr = {$urandom, $urandom};
    in_skip = 2'($urandom); in_wen = 2'($urandom); in_wdest = 16'($urandom);
    in_wdata = {$urandom, $urandom, $urandom, $urandom};
    excp_in_valid = e; excp_in_eret = 1'($urandom); excp_in_intrNo = 11'($urandom);
    excp_in_cause = cause; excp_in_pc = epc; excp_in_inst = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(2'b00, 1'b0, 64'd0, 64'd0, 32'd0, 6'd0);
      tick();
    end
  endtask

  always @(negedge clock) begin
    emit_t x;
    if (mon_on) begin
      check("in_ready", 720'(in_ready), 720'(m_ready_cur));
      check("overflow_err", 720'(overflow_err), 720'(m_ovf_cur));
      check("coreid", 720'(out_coreid), 720'(0));
      if (expq.size() > 0 && expq[0].due == cyc) begin
        x = expq.pop_front();
        check("slots", 720'({out_valid, out_index, out_pc, out_instr, out_skip, out_wen, out_wdest, out_wdata}),
              720'({x.v, x.idx, x.pc, x.instr, x.skip, x.wen, x.wdest, x.wdata}));
        check("excp", 720'({out_excp_valid, out_eret, out_intrNo, out_cause, out_excp_pc, out_excp_inst}),
              720'({x.ev, x.eret, x.intr, x.cause, x.epc, x.einst}));
      end else begin
        check("idle", 720'({out_valid, out_excp_valid, |out_pc, |out_wdata, |out_index, |out_excp_pc}), 720'(0));
      end
    end
  end

  initial begin
    logic [1:0] v;
    int hold_pct;
    reset = 1; out_hold = 0;
    set_in(2'b00, 1'b0, 64'd0, 64'd0, 32'd0, 6'd0);
    tick();
    mon_on = 1;
    tick();
    reset = 0;
    idle(2);

    set_in(2'b11, 1'b0, 64'h1c000000, 64'h1c000004, 32'd0, 6'd0); tick();
    idle(4);

    set_in(2'b01, 1'b1, 64'h1c000010, 64'd0, 32'h1c000014, 6'h0b); tick();
    idle(4);

    out_hold = 1;
    for (int i = 0; i < 9; i++) begin
      set_in(2'b11, 1'b0, pc_ctr, pc_ctr + 64'd4, 32'd0, 6'd0);
      pc_ctr += 64'd8;
      tick();
    end
    check("ovf_sticky", 720'(overflow_err), 720'(1));
    out_hold = 0;
    idle(6);

    set_in(2'b10, 1'b0, 64'd0, 64'h1c000020, 32'd0, 6'd0); tick();
    idle(4);

    out_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(2'b11, 1'b0, pc_ctr, pc_ctr + 64'd4, 32'd0, 6'd0);
      pc_ctr += 64'd8;
      tick();
    end
    set_in(2'b00, 1'b0, 64'd0, 64'd0, 32'd0, 6'd0);
    reset = 1; tick();
    reset = 0; out_hold = 0;
    idle(4);

    hold_pct = 25;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) hold_pct = ($urandom_range(0, 1) == 0) ? 20 : 70;
      out_hold = ($urandom_range(0, 99) < hold_pct);
      v = 2'($urandom);
      set_in(v, ($urandom_range(0, 5) == 0), pc_ctr, pc_ctr + 64'd4, pc_ctr[31:0] + 32'd8, 6'($urandom));
      pc_ctr += 64'd12;
      reset = ($urandom_range(0, 599) == 0);
      tick();
      reset = 0;
    end
    out_hold = 0;
    idle(12);
    check("drained", 720'(expq.size()), 720'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
